// File: rtl/sm_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, stream framing constants and a byte-lane helper.
package sm_imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_WIDTH    = 16;

  // Little-endian lane insert: lane 0 lands in bits 7:0, lane 3 in bits 31:24.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane == 2'(i)) begin
        result[8*i +: 8] = data;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sm_imem_loader_if.sv
// Byte-stream, instruction-memory write and status bundle of the loader.
// The host side uses master; the loader itself uses slave.
interface sm_imem_loader_if #(
  parameter int ADDR_WIDTH = 6
);

  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_rst_n;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start,
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  cpu_rst_n,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output cpu_rst_n,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/sm_imem_loader_timeout.sv
// Loadable down-counter guarding the gap between accepted bytes.
// expired flags the last counted idle cycle before the gap reaches TIMEOUT.
module sm_imem_loader_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(TIMEOUT);
    end else if (count_en && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign expired = count_en && (count_reg == CW'(1));

endmodule

// File: rtl/sm_imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs 32-bit words and
// writes them to instruction memory while holding the CPU in reset.
module sm_imem_loader
  import sm_imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 1000
) (
  input logic            clk,
  input logic            rst,
  sm_imem_loader_if.slave bus
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                 state_reg;
  logic [COUNT_WIDTH-1:0] word_count_reg;
  logic [ADDR_WIDTH:0]    word_idx_reg;
  logic [1:0]             byte_idx_reg;
  logic [31:0]            word_buf_reg;
  logic [7:0]             hdr_lo_reg;

  logic                   in_ready_reg;
  logic                   imem_we_reg;
  logic [ADDR_WIDTH-1:0]  imem_addr_reg;
  logic [31:0]            imem_wdata_reg;
  logic                   cpu_rst_n_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   error_reg;

  logic                   accept;
  logic                   expired;
  logic                   tmr_load;
  logic [COUNT_WIDTH-1:0] hdr_count;
  logic                   oversize;
  logic [ADDR_WIDTH:0]    next_idx;
  logic                   last_word;
  logic [31:0]            packed_word;

  assign accept      = bus.in_valid && in_ready_reg;
  assign hdr_count   = {bus.in_data, hdr_lo_reg};
  assign oversize    = {1'b0, hdr_count} > MAX_WORDS;
  assign next_idx    = word_idx_reg + (ADDR_WIDTH+1)'(1);
  assign last_word   = (COUNT_WIDTH'(next_idx) == word_count_reg);
  assign packed_word = insert_byte(word_buf_reg, byte_idx_reg, bus.in_data);

  // Reloading throughout IDLE means every load starts with a full idle budget.
  assign tmr_load = accept || (state_reg == IDLE);

  sm_imem_loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .count_en (in_ready_reg),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      word_count_reg <= '0;
      word_idx_reg   <= '0;
      byte_idx_reg   <= '0;
      word_buf_reg   <= '0;
      hdr_lo_reg     <= '0;
      in_ready_reg   <= 1'b0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      cpu_rst_n_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      imem_we_reg <= 1'b0;
      if (expired && !accept) begin
        // Stream went quiet: abort and drop whatever partial word was buffered.
        state_reg    <= IDLE;
        in_ready_reg <= 1'b0;
        busy_reg     <= 1'b0;
        error_reg    <= 1'b1;
        byte_idx_reg <= '0;
        word_buf_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start) begin
              state_reg     <= HDR0;
              in_ready_reg  <= 1'b1;
              busy_reg      <= 1'b1;
              done_reg      <= 1'b0;
              error_reg     <= 1'b0;
              cpu_rst_n_reg <= 1'b0;
              word_idx_reg  <= '0;
              byte_idx_reg  <= '0;
              word_buf_reg  <= '0;
            end
          end
          HDR0: begin
            if (accept) begin
              hdr_lo_reg <= bus.in_data;
              state_reg  <= HDR1;
            end
          end
          HDR1: begin
            if (accept) begin
              if (hdr_count == '0) begin
                state_reg     <= IDLE;
                in_ready_reg  <= 1'b0;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b1;
                cpu_rst_n_reg <= 1'b1;
              end else if (oversize) begin
                state_reg    <= IDLE;
                in_ready_reg <= 1'b0;
                busy_reg     <= 1'b0;
                error_reg    <= 1'b1;
              end else begin
                word_count_reg <= hdr_count;
                state_reg      <= DATA;
              end
            end
          end
          DATA: begin
            if (accept) begin
              if (byte_idx_reg == 2'(BYTES_PER_WORD - 1)) begin
                state_reg      <= WRITE;
                in_ready_reg   <= 1'b0;
                imem_we_reg    <= 1'b1;
                imem_addr_reg  <= word_idx_reg[ADDR_WIDTH-1:0];
                imem_wdata_reg <= packed_word;
                byte_idx_reg   <= '0;
                word_buf_reg   <= '0;
              end else begin
                word_buf_reg <= packed_word;
                byte_idx_reg <= byte_idx_reg + 2'd1;
              end
            end
          end
          WRITE: begin
            word_idx_reg <= next_idx;
            if (last_word) begin
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
              cpu_rst_n_reg <= 1'b1;
            end else begin
              state_reg    <= DATA;
              in_ready_reg <= 1'b1;
            end
          end
          default: begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.imem_we    = imem_we_reg;
  assign bus.imem_addr  = imem_addr_reg;
  assign bus.imem_wdata = imem_wdata_reg;
  assign bus.cpu_rst_n  = cpu_rst_n_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.error      = error_reg;

endmodule

// File: doc/sm_imem_loader.md
SM_IMEM_LOADER -- requirements
Module: sm_imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, giving the instruction-memory word-address width (64 words).
REQ-002 SHALL have parameter TIMEOUT, default 1000, giving the maximum idle cycles allowed between accepted bytes during a load.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle load request.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_data  input  8  byte-stream payload.
REQ-008 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  ADDR_WIDTH  word address for the write.
REQ-011 SHALL have port imem_wdata  output  32  assembled instruction word.
REQ-012 SHALL have port cpu_rst_n  output  1  CPU reset, active-low; low holds the CPU in reset.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  last load completed without error.
REQ-015 SHALL have port error  output  1  last load aborted.

Function
REQ-016 SHALL use states IDLE, HDR0, HDR1, DATA, WRITE.
REQ-017 SHALL, in IDLE, move to HDR0 on start, clear done and error, and drive cpu_rst_n low.
REQ-018 SHALL treat a byte as accepted only in a cycle where in_valid and in_ready are both 1.
REQ-019 SHALL drive in_ready to 1 exactly in HDR0, HDR1 and DATA.
REQ-020 SHALL take a 16-bit word count N from the HDR0 byte (low) and the HDR1 byte (high).
REQ-021 SHALL, on N=0, return to IDLE with done=1 after HDR1.
REQ-022 SHALL, on N>2^ADDR_WIDTH, return to IDLE with error=1 after HDR1 and write nothing.
REQ-023 SHALL, in DATA, pack bytes little-endian: the first byte goes to bits 7:0 and the fourth to bits 31:24.
REQ-024 SHALL enter WRITE in the cycle after the fourth byte of a word is accepted.
REQ-025 SHALL assert imem_we for exactly one cycle in WRITE, with imem_addr equal to the word index (starting at 0) and imem_wdata equal to the packed word.
REQ-026 SHALL leave WRITE for DATA if words remain, otherwise for IDLE with done=1.
REQ-027 SHALL drive cpu_rst_n high from the first cycle in IDLE after a successful load.
REQ-028 SHALL keep cpu_rst_n low after an error until a later load succeeds.
REQ-029 SHALL count idle cycles in HDR0, HDR1 and DATA, resetting the count on each accepted byte.
REQ-030 SHALL, when the idle count reaches TIMEOUT, go to IDLE with error=1 and discard any partial word.
REQ-031 SHALL ignore start while busy; a start in the same cycle a load completes is also ignored.
REQ-032 SHALL keep imem_we at 0 outside WRITE.
REQ-033 SHALL hold imem_addr and imem_wdata stable outside WRITE.
REQ-034 SHALL assert busy exactly when the state is not IDLE.

Reset
REQ-035 SHALL, while rst is high, force state IDLE, cpu_rst_n=0, in_ready=0, imem_we=0, busy=0, done=0, error=0, imem_addr=0, imem_wdata=0, and all counters to 0.
REQ-036 SHALL, if rst asserts mid-load, abandon the load at once with no further imem_we; words already written are not undone.

Structure
REQ-037 SHALL put the state encoding and the header byte count (2) in the shared package.
REQ-038 SHALL keep ADDR_WIDTH and TIMEOUT as module parameters.
REQ-039 SHALL have one sub-module, sm_imem_loader_timeout: a loadable down-counter with an expiry flag.

Verification
REQ-040 SHALL verify this normal load: start, then bytes 02 00 13 05 10 00 93 05 20 00 -> writes 0x00100513 at address 0, then 0x00200593 at address 1; done=1; cpu_rst_n high in the next cycle.
REQ-041 SHALL verify back-pressure and stalls: the same load with in_valid toggled every other cycle -> identical writes; no byte lost or duplicated.
REQ-042 SHALL verify an empty load: header 00 00 -> no imem_we; done=1; cpu_rst_n=1.
REQ-043 SHALL verify oversize rejection: with ADDR_WIDTH=6, header 41 00 -> error=1; no imem_we; cpu_rst_n=0.
REQ-044 SHALL verify timeout: with TIMEOUT=10, stop after three data bytes -> error=1 ten cycles after the last accepted byte; no imem_we.
REQ-045 SHALL verify reset mid-load: rst pulsed after one word is written -> all outputs at reset values; a fresh load then completes correctly.
